// File: rtl/fft_bin_reader_pkg.sv
// ============================================================================
// Module      : fft_bin_reader_pkg
// Description : Shared FFT sample constants, reader FSM state type and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_bin_reader_pkg;

    // Sample-format constants, shared with the bin-writer side.
    localparam int          c_nfft_default     = 256;
    localparam int          c_comp_w           = 18;
    localparam int          c_lane_w           = 24;
    localparam int          c_word_w           = 32;
    localparam logic [15:0] c_cfg_word_default = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONFIG = 2'd1,
        ST_READ   = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // Skid FIFO depth: 2*rd_lat+4 rounded up to a power of two.
    function automatic int skid_depth(input int rd_lat);
        int d;
        d = 1;
        for (int i = 0; i < 16; i++) begin
            if (d < 2 * rd_lat + 4) d = d * 2;
        end
        return d;
    endfunction

    function automatic logic [c_lane_w-1:0] sext_lane(input logic [c_comp_w-1:0] v);
        return {{(c_lane_w - c_comp_w){v[c_comp_w-1]}}, v};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fft_bin_reader_if.sv
// ============================================================================
// Module      : fft_bin_reader_if
// Description : BRAM read port plus IFFT config and data stream channels.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fft_bin_reader_if
    import fft_bin_reader_pkg::*;
#(
    parameter int ADDR_W = 9
) ();
    logic                  bram_en;
    logic [ADDR_W-1:0]     bram_addr;
    logic [c_word_w-1:0]   bram_dout;

    logic [15:0]           m_axis_config_tdata;
    logic                  m_axis_config_tvalid;
    logic                  m_axis_config_tready;

    logic [2*c_lane_w-1:0] m_axis_data_tdata;
    logic                  m_axis_data_tvalid;
    logic                  m_axis_data_tready;
    logic                  m_axis_data_tlast;

    modport master (
        output bram_en, bram_addr,
        input  bram_dout,
        output m_axis_config_tdata, m_axis_config_tvalid,
        input  m_axis_config_tready,
        output m_axis_data_tdata, m_axis_data_tvalid, m_axis_data_tlast,
        input  m_axis_data_tready
    );

    modport slave (
        input  bram_en, bram_addr,
        output bram_dout,
        input  m_axis_config_tdata, m_axis_config_tvalid,
        output m_axis_config_tready,
        input  m_axis_data_tdata, m_axis_data_tvalid, m_axis_data_tlast,
        output m_axis_data_tready
    );
endinterface

`default_nettype wire

// File: rtl/fft_bin_skid_fifo.sv
// ============================================================================
// Module      : fft_bin_skid_fifo
// Description : Synchronous show-ahead FIFO with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_bin_skid_fifo
    import fft_bin_reader_pkg::*;
#(
    parameter int WIDTH = c_word_w,
    parameter int DEPTH = 8
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_wr_en,
    input  wire logic [WIDTH-1:0]         i_wr_data,
    input  wire logic                     i_rd_en,
    output logic      [WIDTH-1:0]         o_rd_data,
    output logic      [$clog2(DEPTH):0]   o_count,
    output logic                          o_empty,
    output logic                          o_full
);
    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_cw'(DEPTH));
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign w_wr      = i_wr_en && !o_full;
    assign w_rd      = i_rd_en && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + c_aw'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

`default_nettype wire

// File: rtl/fft_bin_reader.sv
// ============================================================================
// Module      : fft_bin_reader
// Description : Streams one frame of complex FFT bins from BRAM into an IFFT core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_bin_reader
    import fft_bin_reader_pkg::*;
#(
    parameter int          NFFT     = c_nfft_default,
    parameter int          RD_LAT   = 2,
    parameter logic [15:0] CFG_WORD = c_cfg_word_default
) (
    input  wire logic           sys_clk,
    input  wire logic           reset,
    input  wire logic           start,
    fft_bin_reader_if.master    bus,
    output logic                busy,
    output logic                done,
    output logic                start_dropped
);
    localparam int c_addr_w = $clog2(2 * NFFT);
    localparam int c_bin_w  = $clog2(NFFT);
    localparam int c_depth  = skid_depth(RD_LAT);
    localparam int c_cnt_w  = $clog2(c_depth) + 1;
    localparam int c_sum_w  = c_cnt_w + 1;
    localparam logic [c_addr_w-1:0] c_last_addr = c_addr_w'(2 * NFFT - 1);
    localparam logic [c_bin_w-1:0]  c_last_bin  = c_bin_w'(NFFT - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [c_addr_w-1:0]   r_addr;
    logic [c_bin_w-1:0]    r_bin;
    logic [RD_LAT-1:0]     r_vld_sr;
    logic [c_comp_w-1:0]   r_real;
    logic                  r_have_real;
    logic                  r_done;
    logic                  r_start_dropped;

    logic [c_word_w-1:0]   w_head;
    logic [c_cnt_w-1:0]    w_occ;
    logic [c_cnt_w-1:0]    w_inflight;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_credit_ok;
    logic                  w_issue;
    logic                  w_tvalid;
    logic                  w_fire;
    logic                  w_last_fire;
    logic                  w_pop;
    logic                  w_accept;
    logic                  w_unused_bits;

    fft_bin_skid_fifo #(
        .WIDTH (c_word_w),
        .DEPTH (c_depth)
    ) u_skid (
        .clk       (sys_clk),
        .rst       (reset),
        .i_wr_en   (r_vld_sr[RD_LAT-1]),
        .i_wr_data (bus.bram_dout),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_count   (w_occ),
        .o_empty   (w_empty),
        .o_full    (w_full)
    );

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + c_cnt_w'(r_vld_sr[i]);
        end
    end

    // Never issue a read whose data could not land in the FIFO under backpressure.
    assign w_credit_ok = (c_sum_w'(w_occ) + c_sum_w'(w_inflight) + c_sum_w'(1))
                         <= c_sum_w'(c_depth);
    assign w_issue     = (r_state == ST_READ) && w_credit_ok;

    // The real word waits in r_real; the imag word is the FIFO head until accepted.
    assign w_tvalid    = r_have_real && !w_empty;
    assign w_fire      = w_tvalid && bus.m_axis_data_tready;
    assign w_last_fire = w_fire && (r_bin == c_last_bin);
    assign w_pop       = w_fire || (!r_have_real && !w_empty);
    assign w_accept    = start && (r_state == ST_IDLE) && !r_done;

    assign w_unused_bits = ^{w_head[c_word_w-1:c_comp_w], w_full};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_next = ST_CONFIG;
            ST_CONFIG: if (bus.m_axis_config_tready) w_state_next = ST_READ;
            ST_READ:   if (w_issue && (r_addr == c_last_addr)) w_state_next = ST_DRAIN;
            ST_DRAIN:  if (w_last_fire) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_addr          <= '0;
            r_bin           <= '0;
            r_vld_sr        <= '0;
            r_real          <= '0;
            r_have_real     <= 1'b0;
            r_done          <= 1'b0;
            r_start_dropped <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_issue) r_addr <= r_addr + c_addr_w'(1);

            r_vld_sr[0] <= w_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_sr[i] <= r_vld_sr[i-1];
            end

            if (!r_have_real && !w_empty) begin
                r_real      <= w_head[c_comp_w-1:0];
                r_have_real <= 1'b1;
            end else if (w_fire) begin
                r_have_real <= 1'b0;
            end

            if (w_fire) r_bin <= r_bin + c_bin_w'(1);
            r_done <= w_last_fire;

            if (w_accept)   r_start_dropped <= 1'b0;
            else if (start) r_start_dropped <= 1'b1;
        end
    end

    assign bus.bram_en              = w_issue;
    assign bus.bram_addr            = r_addr;
    assign bus.m_axis_config_tvalid = (r_state == ST_CONFIG);
    assign bus.m_axis_config_tdata  = (r_state == ST_CONFIG) ? CFG_WORD : 16'h0000;
    assign bus.m_axis_data_tvalid   = w_tvalid;
    assign bus.m_axis_data_tlast    = w_tvalid && (r_bin == c_last_bin);
    assign bus.m_axis_data_tdata    = w_tvalid ? {sext_lane(w_head[c_comp_w-1:0]), sext_lane(r_real)}
                                               : '0;
    assign busy                     = (r_state != ST_IDLE);
    assign done                     = r_done;
    assign start_dropped            = r_start_dropped;

endmodule

`default_nettype wire

// File: tb/tb_fft_bin_reader.sv
// ============================================================================
// Module      : tb_fft_bin_reader
// Description : Randomized scoreboard bench for fft_bin_reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fft_bin_reader;
    import fft_bin_reader_pkg::*;

    localparam int NFFT   = 256;
    localparam int RD_LAT = 2;
    localparam int ADDR_W = $clog2(2 * NFFT);
    localparam int LIMIT  = 20000;

    typedef struct {
        logic [47:0] data;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;
    logic start_dropped;

    always #5 clk = ~clk;

    fft_bin_reader_if #(.ADDR_W(ADDR_W)) bus ();

    fft_bin_reader #(
        .NFFT     (NFFT),
        .RD_LAT   (RD_LAT),
        .CFG_WORD (16'h0000)
    ) dut (
        .sys_clk       (clk),
        .reset         (rst),
        .start         (start),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .start_dropped (start_dropped)
    );

    int          checks = 0;
    int          errors = 0;
    beat_t       exp_q[$];
    logic [31:0] mem [2*NFFT];
    logic [31:0] pipe [RD_LAT];
    logic [47:0] cap [NFFT];
    int          ready_pct = 100;
    int          cyc = 0;
    int          beats, tlast_cnt, done_cnt;
    int          hs_cyc, first_valid, first_fire, last_fire;
    int          exp_addr = 0;
    logic        prev_stall = 1'b0;
    logic [47:0] prev_data;
    logic        prev_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: bin k = sign-extended 18-bit values of words 2k and 2k+1.
    function automatic logic [23:0] lane(input logic [31:0] w);
        int v;
        v = int'(w[17:0]);
        if (v >= 131072) v = v - 262144;
        return 24'(v);
    endfunction

    task automatic clear_counters();
        beats = 0; tlast_cnt = 0; done_cnt = 0;
        hs_cyc = -1; first_valid = -1; first_fire = -1; last_fire = -1;
    endtask

    task automatic push_frame();
        beat_t b;
        clear_counters();
        for (int k = 0; k < NFFT; k++) begin
            b.data = {lane(mem[2*k+1]), lane(mem[2*k])};
            b.last = (k == NFFT - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic do_start(input bit expect_accept);
        @(posedge clk); #1;
        start = 1'b1;
        if (expect_accept) push_frame();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < LIMIT) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= LIMIT) begin
            errors++;
            $display("FAIL %s_timeout: %0d beats still pending, required 0", name, exp_q.size());
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_bram_en"},   64'(bus.bram_en), 64'd0);
        chk({tag, "_bram_addr"}, 64'(bus.bram_addr), 64'd0);
        chk({tag, "_tvalid"},    64'(bus.m_axis_data_tvalid), 64'd0);
        chk({tag, "_tlast"},     64'(bus.m_axis_data_tlast), 64'd0);
        chk({tag, "_tdata"},     64'(bus.m_axis_data_tdata), 64'd0);
        chk({tag, "_cfg_valid"}, 64'(bus.m_axis_config_tvalid), 64'd0);
        chk({tag, "_busy"},      64'(busy), 64'd0);
        chk({tag, "_done"},      64'(done), 64'd0);
        chk({tag, "_dropped"},   64'(start_dropped), 64'd0);
    endtask

    // BRAM model with RD_LAT-cycle read latency; idle cycles return garbage.
    always @(posedge clk) begin
        for (int i = RD_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= bus.bram_en ? mem[bus.bram_addr] : 32'hDEAD_BEEF;
    end
    assign bus.bram_dout = pipe[RD_LAT-1];

    always @(posedge clk) begin
        #1;
        bus.m_axis_data_tready = ($urandom_range(99) < ready_pct);
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_tvalid", 64'(bus.m_axis_data_tvalid), 64'd1);
                chk("stall_tdata",  64'(bus.m_axis_data_tdata), 64'(prev_data));
                chk("stall_tlast",  64'(bus.m_axis_data_tlast), 64'(prev_last));
            end
            if (bus.m_axis_config_tvalid && bus.m_axis_config_tready) hs_cyc = cyc;
            if (bus.m_axis_data_tvalid && first_valid < 0 && hs_cyc >= 0) first_valid = cyc;
            if (bus.bram_en) begin
                chk("bram_addr_order", 64'(bus.bram_addr), 64'(exp_addr));
                chk("bram_en_in_config", 64'(bus.m_axis_config_tvalid), 64'd0);
                exp_addr = (exp_addr + 1) % (2 * NFFT);
            end
            if (bus.m_axis_data_tvalid && bus.m_axis_data_tready) begin
                if (first_fire < 0) first_fire = cyc;
                last_fire = cyc;
                if (beats < NFFT) cap[beats] = bus.m_axis_data_tdata;
                if (bus.m_axis_data_tlast) tlast_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", bus.m_axis_data_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 64'(bus.m_axis_data_tdata), 64'(e.data));
                    chk("beat_last", 64'(bus.m_axis_data_tlast), 64'(e.last));
                end
                beats++;
            end
            if (done) done_cnt++;
            prev_stall = bus.m_axis_data_tvalid && !bus.m_axis_data_tready;
            prev_data  = bus.m_axis_data_tdata;
            prev_last  = bus.m_axis_data_tlast;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        bus.m_axis_config_tready = 1'b1;
        clear_counters();
        for (int i = 0; i < 2 * NFFT; i++) mem[i] = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Sparse frame: one positive full-scale and one negative full-scale bin.
        mem[2]  = 32'h0001FFFF;
        mem[12] = 32'h00020000;
        do_start(1'b1);
        wait_frame("sparse");
        chk("sparse_beats", 64'(beats), 64'(NFFT));
        chk("sparse_tlast_count", 64'(tlast_cnt), 64'd1);
        chk("sparse_done_count", 64'(done_cnt), 64'd1);
        chk("sparse_bin0_real", 64'(cap[0][23:0]), 64'h0);
        chk("sparse_bin1_real", 64'(cap[1][23:0]), 64'h01FFFF);
        chk("sparse_bin6_real", 64'(cap[6][23:0]), 64'hFE0000);
        chk("first_valid_latency_ok", 64'((first_valid - hs_cyc) <= RD_LAT + 3), 64'd1);
        chk("frame_span_cycles", 64'(last_fire - first_fire), 64'(2 * (NFFT - 1)));

        // Ramp frame with random backpressure.
        for (int k = 0; k < NFFT; k++) begin
            mem[2*k]   = 32'(k);
            mem[2*k+1] = 32'(-k);
        end
        ready_pct = 70;
        do_start(1'b1);
        wait_frame("ramp");
        chk("ramp_beats", 64'(beats), 64'(NFFT));
        chk("ramp_done_count", 64'(done_cnt), 64'd1);
        chk("ramp_bin5", 64'(cap[5]), 64'({24'hFFFFFB, 24'h000005}));

        // Config channel stalled for 20 cycles.
        for (int i = 0; i < 2 * NFFT; i++) mem[i] = $urandom;
        ready_pct = 100;
        bus.m_axis_config_tready = 1'b0;
        do_start(1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("cfg_hold_bram_en", 64'(bus.bram_en), 64'd0);
            chk("cfg_hold_tvalid", 64'(bus.m_axis_config_tvalid), 64'd1);
            chk("cfg_hold_tdata", 64'(bus.m_axis_config_tdata), 64'h0000);
        end
        @(posedge clk); #1;
        bus.m_axis_config_tready = 1'b1;
        wait_frame("cfg_stall");
        chk("cfg_stall_beats", 64'(beats), 64'(NFFT));

        // Start while busy is dropped and flagged.
        ready_pct = 60;
        for (int i = 0; i < 2 * NFFT; i++) mem[i] = $urandom;
        do_start(1'b1);
        repeat (8) @(posedge clk);
        do_start(1'b0);
        @(negedge clk);
        chk("dropped_set", 64'(start_dropped), 64'd1);
        wait_frame("drop");
        chk("drop_beats", 64'(beats), 64'(NFFT));
        chk("drop_done_count", 64'(done_cnt), 64'd1);
        chk("dropped_sticky", 64'(start_dropped), 64'd1);

        // Accepted start clears the flag; then start coincident with done.
        ready_pct = 100;
        do_start(1'b1);
        @(negedge clk);
        chk("dropped_cleared", 64'(start_dropped), 64'd0);
        n = 0;
        while (!(bus.m_axis_data_tvalid && bus.m_axis_data_tready && bus.m_axis_data_tlast)
               && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("tlast_seen", 64'(n < LIMIT), 64'd1);
        @(posedge clk); #1;
        start = 1'b1;
        @(negedge clk);
        chk("coincident_done", 64'(done), 64'd1);
        chk("coincident_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        push_frame();
        @(negedge clk);
        chk("coincident_dropped", 64'(start_dropped), 64'd1);
        chk("after_done_idle", 64'(busy), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("after_done_accepted", 64'(busy), 64'd1);
        chk("after_done_cleared", 64'(start_dropped), 64'd0);
        wait_frame("after_done");
        chk("after_done_beats", 64'(beats), 64'(NFFT));

        // Reset at beat 100 aborts the frame.
        for (int i = 0; i < 2 * NFFT; i++) mem[i] = $urandom;
        do_start(1'b1);
        do_start(1'b0);
        n = 0;
        while (beats < 100 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("reached_beat_100", 64'(n < LIMIT), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        exp_q.delete();
        exp_addr = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_counters();
        repeat (10) @(negedge clk);
        chk("post_reset_beats", 64'(beats), 64'd0);
        chk("post_reset_done", 64'(done_cnt), 64'd0);
        ready_pct = 75;
        do_start(1'b1);
        wait_frame("post_reset");
        chk("post_reset_frame_beats", 64'(beats), 64'(NFFT));
        chk("post_reset_frame_done", 64'(done_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fft_bin_reader.md
FFT_BIN_READER -- requirements
Module: fft_bin_reader

Interface
REQ-001 Parameter NFFT, 256, number of frequency bins per frame (power of two, 8..1024).
REQ-002 Parameter RD_LAT, 2, bin BRAM read latency in cycles (1..3).
REQ-003 Parameter CFG_WORD, 16'h0000, IFFT core config word; bit0=0 selects inverse transform.
REQ-004 sys_clk  in  1  single clock for all logic; BRAM read port and stream ports are synchronous to it.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse requesting transfer of one bin frame; already synchronous to sys_clk.
REQ-007 bram_en  out  1  BRAM read enable.
REQ-008 bram_addr  out  log2(2*NFFT)  word address; bin k real part at 2k, imaginary part at 2k+1.
REQ-009 bram_dout  in  32  read data, valid RD_LAT cycles after bram_en; bits [17:0] are a two's-complement component.
REQ-010 m_axis_config_tdata/tvalid/tready  out/out/in  16/1/1  IFFT config channel.
REQ-011 m_axis_data_tdata  out  48  [23:0]=real, [47:24]=imag, each sign-extended from 18 bits.
REQ-012 m_axis_data_tvalid/tready/tlast  out/in/out  1/1/1  data channel handshake; tlast marks bin NFFT-1.
REQ-013 busy  out  1  high from accepted start until frame complete.
REQ-014 done  out  1  one-cycle pulse when last bin handshake completes.
REQ-015 start_dropped  out  1  sticky flag: start seen while busy.

Function
REQ-016 FSM states IDLE, CONFIG, READ, DRAIN; IDLE->CONFIG on start; CONFIG->READ on config handshake; READ->DRAIN when all 2*NFFT reads issued; DRAIN->IDLE on tlast handshake.
REQ-017 CONFIG: m_axis_config_tvalid high with tdata=CFG_WORD until tready; no BRAM reads issued in CONFIG.
REQ-018 READ: addresses issued in ascending order 0..2*NFFT-1, one per cycle while credit is available.
REQ-019 Credit rule: a read is issued only if (skid FIFO occupancy + reads in flight + 1) <= FIFO depth in words; no BRAM data is ever lost under tready=0.
REQ-020 Read data return is tracked by an RD_LAT-deep valid shift register; returned words are written into the skid FIFO in issue order.
REQ-021 A data beat is formed from an even (real) word followed by its odd (imag) word; tvalid asserts only when both are present.
REQ-022 tdata/tvalid/tlast hold stable while tvalid=1 and tready=0.
REQ-023 With tready held high, steady-state throughput is one bin per two cycles; first tvalid no later than RD_LAT+3 cycles after config handshake.
REQ-024 Bin counter wraps at NFFT; tlast asserted exactly on bin NFFT-1; done pulses the cycle after that handshake.
REQ-025 start while busy=1 is ignored and sets start_dropped; start_dropped clears on next accepted start.
REQ-026 start coincident with done (same cycle) is treated as busy and dropped.
REQ-027 busy deasserts the cycle done pulses; a start the following cycle is accepted.

Reset
REQ-028 On reset: state=IDLE, bram_en=0, bram_addr=0, all tvalid=0, tlast=0, tdata=0, busy=0, done=0, start_dropped=0, FIFO empty, in-flight count 0.
REQ-029 Reset asserted mid-frame aborts the frame immediately; no partial tlast or done is produced after release.
REQ-030 First start after reset release produces a complete frame from bin 0.

Structure
REQ-031 NFFT default, component width 18, lane width 24, and CFG_WORD default live in the shared FFT sample defines include, used also by the bin-writer side.
REQ-032 One sub-module: fft_bin_skid_fifo, synchronous FIFO, 32-bit wide, depth 2*RD_LAT+4 rounded to a power of two, with occupancy output.
REQ-033 Implementation 120-400 lines; no vendor primitives.

Verification
REQ-034 BRAM all zero except word2=0x0001FFFF, word12=0x00020000; start, tready=1 -> bin1 tdata[23:0]=0x01FFFF, bin6 tdata[23:0]=0xFE0000, all others 0, 256 beats, tlast on beat 255, one done.
REQ-035 Word 2k=k, 2k+1=-k; tready random 30% -> beat k real=k, imag=-k sign-extended, no drops or duplicates, tdata stable across stalls.
REQ-036 config tready held low 20 cycles -> no bram_en during those cycles, config tdata=0x0000 throughout, data follows after handshake.
REQ-037 Second start 10 cycles into a frame -> frame unaffected, start_dropped=1; next accepted start clears it.
REQ-038 Reset asserted at beat 100 -> all outputs at reset values next edge; new start yields full 256-beat frame from bin 0.
REQ-039 RD_LAT=1 and RD_LAT=3 builds with tready=1 -> one bin per two cycles after first beat, identical data to RD_LAT=2.
